// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter.
// On an accepted start it sends PATTERN (MSB first) rep times (0 means 16),
// with gap idle cycles between copies, then pulses done for one cycle.
// Optional build macro: SEQ_GEN_LFSR_EN -- idle/gap filler bits come from a
// 7-bit Fibonacci LFSR (x^7+x^6+1, seed 7'h5A) instead of the constant IDLE_BIT.
module seq_gen #(
  parameter int               WIDTH    = 7,
  parameter logic [WIDTH-1:0] PATTERN  = 7'b1110010,
  parameter logic             IDLE_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] rep,
  input  logic [3:0] gap,
  output logic       ready,
  output logic       x,
  output logic       frame,
  output logic       done
);

  localparam int            IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_idx;       // index of the pattern bit currently on x
  logic [4:0]    r_copies;    // copies still to send, including the current one
  logic [3:0]    r_gap_len;   // gap length latched at acceptance
  logic [3:0]    r_gap_cnt;   // idle cycles left in the current gap, including this one
  logic          r_x;
  logic          r_frame;
  logic          r_done;

  logic [IW-1:0] w_idx_dec;
  logic          w_idle_nxt;  // filler level that x must show in the next cycle

  assign w_idx_dec = r_idx - 1'b1;

`ifdef SEQ_GEN_LFSR_EN
  localparam logic [6:0] LFSR_SEED = 7'h5A;
  localparam logic       RST_X     = LFSR_SEED[0];

  logic [6:0] r_lfsr;
  logic [6:0] w_lfsr_nxt;

  // The LFSR free-runs while filler is on the line and freezes while a copy is sent.
  assign w_lfsr_nxt = (r_state == ST_SEND) ? r_lfsr
                                           : {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
  assign w_idle_nxt = w_lfsr_nxt[0];

  // LFSR state register, restarted from the seed on reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= w_lfsr_nxt;
    end
  end
`else
  localparam logic RST_X = IDLE_BIT;

  assign w_idle_nxt = IDLE_BIT;
`endif

  // Transmit FSM: state, counters and all three registered outputs move together.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the later assignments below override defaults.
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_copies  <= '0;
      r_gap_len <= '0;
      r_gap_cnt <= '0;
      r_x       <= RST_X;
      r_frame   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_x     <= w_idle_nxt;
          r_frame <= 1'b0;
          if (start) begin
            r_state   <= ST_SEND;
            r_copies  <= (rep == 4'd0) ? 5'd16 : {1'b0, rep};
            r_gap_len <= gap;
            r_idx     <= LAST_IDX;
            r_x       <= PATTERN[LAST_IDX];
            r_frame   <= 1'b1;
          end
        end

        ST_SEND: begin
          if (r_idx != '0) begin
            r_idx <= w_idx_dec;
            r_x   <= PATTERN[w_idx_dec];
          end else if (r_copies > 5'd1) begin
            r_copies <= r_copies - 5'd1;
            if (r_gap_len != 4'd0) begin
              r_state   <= ST_GAP;
              r_gap_cnt <= r_gap_len;
              r_x       <= w_idle_nxt;
              r_frame   <= 1'b0;
            end else begin
              // Zero gap: next copy's MSB follows the LSB directly.
              r_idx <= LAST_IDX;
              r_x   <= PATTERN[LAST_IDX];
            end
          end else begin
            r_state  <= ST_IDLE;
            r_copies <= '0;
            r_x      <= w_idle_nxt;
            r_frame  <= 1'b0;
            r_done   <= 1'b1;
          end
        end

        ST_GAP: begin
          r_x <= w_idle_nxt;
          if (r_gap_cnt == 4'd1) begin
            r_state   <= ST_SEND;
            r_gap_cnt <= '0;
            r_idx     <= LAST_IDX;
            r_x       <= PATTERN[LAST_IDX];
            r_frame   <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_frame <= 1'b0;
          r_x     <= w_idle_nxt;
        end
      endcase
    end
  end

  assign ready = (r_state == ST_IDLE);
  assign x     = r_x;
  assign frame = r_frame;
  assign done  = r_done;

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed bench for seq_gen (default build, constant idle level 0).
// A queue-based model expands each accepted request into the per-cycle output
// sequence and is compared against the DUT every cycle; directed tests add
// hand-computed literal expectations.
module tb_seq_gen;

  localparam int           W   = 7;
  localparam logic [W-1:0] PAT = 7'b1110010;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] rep   = 4'd0;
  logic [3:0] gap   = 4'd0;
  logic       ready;
  logic       x;
  logic       frame;
  logic       done;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seq_gen dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .rep   (rep),
    .gap   (gap),
    .ready (ready),
    .x     (x),
    .frame (frame),
    .done  (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic ready;
    logic x;
    logic frame;
    logic done;
  } exp_t;

  function automatic exp_t mk(input logic r, input logic xx, input logic f, input logic d);
    mk = {r, xx, f, d};
  endfunction

  exp_t q[$];
  exp_t cur = 4'b1000;

  // On each edge: expand an accepted request into its full output sequence,
  // then pop the expectation for the cycle that starts at this edge.
  always @(posedge clk) begin
    int n;
    if (!reset) begin
      q.delete();
      cur <= mk(1'b1, 1'b0, 1'b0, 1'b0);
    end else begin
      if (start && cur.ready) begin
        n = (rep == 4'd0) ? 16 : int'(rep);
        for (int c = 0; c < n; c++) begin
          for (int b = W - 1; b >= 0; b--) q.push_back(mk(1'b0, PAT[b], 1'b1, 1'b0));
          if (c < n - 1)
            for (int g = 0; g < int'(gap); g++) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
        end
        q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1));
      end
      if (q.size() > 0) cur <= q.pop_front();
      else              cur <= mk(1'b1, 1'b0, 1'b0, 1'b0);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_ready", ready, cur.ready);
      check("model_x",     x,     cur.x);
      check("model_frame", frame, cur.frame);
      check("model_done",  done,  cur.done);
    end
  end

  // ---------------- driver helpers ----------------
  // Called at a falling edge; returns at the falling edge of cycle T0+1.
  task automatic go(input logic [3:0] r, input logic [3:0] g);
    start = 1'b1;
    rep   = r;
    gap   = g;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts DUT activity from the current cycle up to and including done.
  task automatic measure(input int budget, output int busy, output int fcyc,
                         output int nfr, output int nd);
    logic pf;
    pf = 1'b0; busy = 0; fcyc = 0; nfr = 0; nd = 0;
    for (int i = 0; i < budget; i++) begin
      if (!ready) busy++;
      if (frame) fcyc++;
      if (frame && !pf) nfr++;
      pf = frame;
      if (done) begin
        nd++;
        return;
      end
      @(negedge clk);
    end
    check("done_timeout", nd, 1);
  endtask

  // Sends one copy (optionally poking start mid-copy) and checks it literally.
  task automatic single_copy(input string tag, input bit poke);
    logic [6:0] bits;
    int nf;
    nf = 0;
    go(4'd1, 4'd0);
    for (int i = 0; i < 7; i++) begin
      bits[6-i] = x;
      if (frame) nf++;
      if (poke && i == 2) begin start = 1'b1; rep = 4'd5; end
      if (poke && i == 3) start = 1'b0;
      @(negedge clk);
    end
    check({tag, "_bits"},   bits,  7'b1110010);
    check({tag, "_frames"}, nf,    7);
    check({tag, "_done"},   done,  1);
    check({tag, "_ready"},  ready, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int busy, fcyc, nfr, nd;

    // Reset held for two edges.
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_x",     x,     0);
    check("rst_frame", frame, 0);
    check("rst_done",  done,  0);
    reset  = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single copy, then restart in the done cycle (rep=2, gap=3).
    single_copy("single", 1'b0);
    go(4'd2, 4'd3);
    measure(100, busy, fcyc, nfr, nd);
    check("restart_busy",   busy, 17);
    check("restart_frames", nfr,  2);
    repeat (3) @(negedge clk);

    // Repeat with gap.
    go(4'd3, 4'd2);
    measure(200, busy, fcyc, nfr, nd);
    check("rep3_busy",   busy, 25);
    check("rep3_fcyc",   fcyc, 21);
    check("rep3_frames", nfr,  3);
    check("rep3_done",   nd,   1);
    repeat (3) @(negedge clk);

    // rep=0 means 16 back-to-back copies.
    go(4'd0, 4'd0);
    measure(300, busy, fcyc, nfr, nd);
    check("rep16_busy",   busy, 112);
    check("rep16_fcyc",   fcyc, 112);
    check("rep16_frames", nfr,  1);
    check("rep16_done",   nd,   1);
    repeat (3) @(negedge clk);

    // Start while busy is ignored.
    single_copy("busy_start", 1'b1);
    repeat (3) @(negedge clk);

    // Mid-frame reset during cycle T0+4.
    go(4'd2, 4'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_x",     x,     0);
    check("midrst_frame", frame, 0);
    check("midrst_ready", ready, 1);
    check("midrst_done",  done,  0);
    reset = 1'b1;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("midrst_no_done", nd, 0);
    single_copy("post_rst", 1'b0);
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
